// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite SRAM responder.
// Optional random latency is enabled with the AXI_SRAM_RAND_LAT_EN macro.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } wr_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Fibonacci form of x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/lat_counter.sv
// Per-channel access-latency down-counter; done while the count is zero.
// With AXI_SRAM_RAND_LAT_EN defined, adds 0..7 cycles from an LFSR per load.
module lat_counter
   import axi_lite_pkg::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
`ifdef AXI_SRAM_RAND_LAT_EN
   input  logic peer_load,
   input  logic defer,
`endif
   output logic done
);

   logic [7:0] cnt;
   logic [7:0] load_val;

`ifdef AXI_SRAM_RAND_LAT_EN
   // Both instances keep an identical copy stepped by the same events; the
   // deferred channel takes the value after the peer's step in a shared cycle.
   logic [7:0] lfsr;
   logic [7:0] lfsr_use;

   always_comb begin
      lfsr_use = (defer && peer_load) ? lfsr_next(lfsr) : lfsr;
      load_val = 8'(LAT - 1) + {5'b0, lfsr_use[2:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lfsr <= LFSR_SEED;
      else if (load && peer_load)
         lfsr <= lfsr_next(lfsr_next(lfsr));
      else if (load || peer_load)
         lfsr <= lfsr_next(lfsr);
   end
`else
   always_comb load_val = 8'(LAT - 1);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 8'd1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite SRAM responder: independent read/write FSMs, programmable latency,
// byte strobes, SLVERR outside the mapped window. Macro: AXI_SRAM_RAND_LAT_EN.
module axi_lite_sram
   import axi_lite_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 32,
   parameter int unsigned         DATA_W    = 32,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'h8000_0000,
   parameter int unsigned         DEPTH     = 4096,
   parameter int unsigned         RD_LAT    = 1,
   parameter int unsigned         WR_LAT    = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < ADDR_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   // ---------------- read channel ----------------
   rd_state_t         rd_state, rd_next;
   logic [ADDR_W-1:0] ar_addr_q;
   logic              ar_accept, rd_sample, rd_done, rd_ok;
   logic              arready_d, rvalid_d;

   assign ar_accept = (rd_state == R_IDLE) && arvalid && arready;
   assign rd_sample = (rd_state == R_WAIT) && rd_done;
   assign rd_ok     = in_range(ar_addr_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state <= R_IDLE;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
      end else begin
         rd_state <= rd_next;
         arready  <= arready_d;
         rvalid   <= rvalid_d;
      end
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_accept) rd_next = R_WAIT;
         R_WAIT:  if (rd_done)   rd_next = R_RESP;
         R_RESP:  if (rready)    rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready_d = (rd_next == R_IDLE);
      rvalid_d  = (rd_next == R_RESP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ar_addr_q <= '0;
         rdata     <= '0;
         rresp     <= RESP_OKAY;
      end else begin
         if (ar_accept)
            ar_addr_q <= araddr;
         if (rd_sample) begin
            rdata <= rd_ok ? mem[word_idx(ar_addr_q)] : '0;
            rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // ---------------- write channel ----------------
   wr_state_t           wr_state, wr_next;
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                aw_held, w_held, aw_held_d, w_held_d;
   logic                aw_hs, w_hs, aw_have, w_have;
   logic                wr_accept, wr_commit, wr_done, wr_ok;
   logic                awready_d, wready_d, bvalid_d;

   assign aw_hs     = awvalid && awready;
   assign w_hs      = wvalid && wready;
   assign aw_have   = aw_held || aw_hs;
   assign w_have    = w_held || w_hs;
   assign wr_accept = (wr_state == W_IDLE) && aw_have && w_have;
   assign wr_commit = (wr_state == W_WAIT) && wr_done;
   assign wr_ok     = in_range(aw_addr_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_state <= W_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
      end else begin
         wr_state <= wr_next;
         aw_held  <= aw_held_d;
         w_held   <= w_held_d;
         awready  <= awready_d;
         wready   <= wready_d;
         bvalid   <= bvalid_d;
      end
   end

   // AW and W are captured independently; the held flags track which half is in.
   always_comb begin
      wr_next   = wr_state;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (wr_accept) begin
               wr_next = W_WAIT;
            end else begin
               aw_held_d = aw_have;
               w_held_d  = w_have;
            end
         end
         W_WAIT:  if (wr_done) wr_next = W_RESP;
         W_RESP:  if (bready)  wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      awready_d = (wr_next == W_IDLE) && !aw_held_d;
      wready_d  = (wr_next == W_IDLE) && !w_held_d;
      bvalid_d  = (wr_next == W_RESP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp     <= RESP_OKAY;
      end else begin
         if (aw_hs)
            aw_addr_q <= awaddr;
         if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (wr_commit)
            bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_commit && wr_ok) begin
         for (int unsigned i = 0; i < DATA_W/8; i++)
            if (wstrb_q[i])
               mem[word_idx(aw_addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
      end
   end

   lat_counter #(.LAT(RD_LAT)) u_rd_lat (
      .clk       (clk),
      .rst       (rst),
      .load      (ar_accept),
`ifdef AXI_SRAM_RAND_LAT_EN
      .peer_load (wr_accept),
      .defer     (1'b0),
`endif
      .done      (rd_done)
   );

   lat_counter #(.LAT(WR_LAT)) u_wr_lat (
      .clk       (clk),
      .rst       (rst),
      .load      (wr_accept),
`ifdef AXI_SRAM_RAND_LAT_EN
      .peer_load (ar_accept),
      .defer     (ar_accept),
`endif
      .done      (wr_done)
   );

endmodule
